// File: rtl/scc_mem_pkg.sv
// scc_mem_pkg: shared FSM state encoding, requester IDs and default latency for the memory port arbiter.
package scc_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;
    localparam int MEM_LAT_DEF = 2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory bus of the unified memory arbiter.
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if
    );
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if
    );
endinterface

// File: rtl/arb_prio_streak.sv
// arb_prio_streak: data-priority winner select with a saturating D streak that lets a waiting fetch through.
module arb_prio_streak
    import scc_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic d_req,
    input  logic take,
    output logic winner
);
    logic [3:0] d_streak;
    logic       at_max;

    always_comb begin
        at_max = d_streak == 4'(MAX_D_STREAK);
        winner = (d_req && !(f_req && at_max)) ? REQ_D : REQ_F;
    end

    // Only D wins taken against a pending fetch extend the streak.
    always_ff @(posedge clk or posedge reset)
        if (reset)
            d_streak <= '0;
        else if (take)
            d_streak <= (winner == REQ_D && f_req) ? (at_max ? d_streak : d_streak + 4'd1) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one access outstanding.
// Define MEM_ARB_STATS_EN to add saturating grant and conflict counters.
module mem_port_arbiter
    import scc_mem_pkg::*;
#(
    parameter int MEM_LAT      = MEM_LAT_DEF,
    parameter int MAX_D_STREAK = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_f_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_conflicts
`endif
);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    state_t        state, state_nx;
    logic          win, win_nx, take, issue, resp, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    lat_cnt;

    assign take = state == IDLE && (bus.f_req || bus.d_req);

    arb_prio_streak #(.MAX_D_STREAK(MAX_D_STREAK)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .f_req  (bus.f_req),
        .d_req  (bus.d_req),
        .take   (take),
        .winner (win_nx)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            win     <= REQ_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_cnt <= '0;
        end else begin
            if (take) begin
                win     <= win_nx;
                we_q    <= win_nx == REQ_D && bus.d_we;
                addr_q  <= (win_nx == REQ_D ? bus.d_addr : bus.f_addr) & WORD_MASK;
                wdata_q <= win_nx == REQ_D ? bus.d_wdata : '0;
            end
            if (state == ISSUE)
                lat_cnt <= 4'(MEM_LAT - 1);
            else if (state == WAIT)
                lat_cnt <= lat_cnt - 4'd1;
        end

    // WAIT is left on the cycle lat_cnt steps from 1 to 0, so RESP lands MEM_LAT cycles after ISSUE.
    always_comb begin
        state_nx      = state == IDLE  ? (take ? ISSUE : IDLE) :
                        state == ISSUE ? (MEM_LAT == 1 ? RESP : WAIT) :
                        state == WAIT  ? (lat_cnt == 4'd1 ? RESP : WAIT) : IDLE;
        issue         = state == ISSUE;
        resp          = state == RESP;
        bus.f_gnt     = issue && win == REQ_F;
        bus.d_gnt     = issue && win == REQ_D;
        bus.mem_en    = issue;
        bus.mem_we    = issue && we_q;
        bus.mem_addr  = issue ? addr_q : '0;
        bus.mem_wdata = issue ? wdata_q : '0;
        bus.f_rvalid  = resp && win == REQ_F;
        bus.d_rvalid  = resp && win == REQ_D;
        bus.f_rdata   = bus.f_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : '0;
        bus.stall_if  = bus.f_req && !bus.f_gnt;
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stat_f_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (bus.f_gnt && stat_f_grants != 16'hFFFF)
                stat_f_grants <= stat_f_grants + 16'd1;
            if (bus.d_gnt && stat_d_grants != 16'hFFFF)
                stat_d_grants <= stat_d_grants + 16'd1;
            if (state == IDLE && bus.f_req && bus.d_req && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
`endif
endmodule
